// File: rtl/riscv_mpsoc_trace_pkg.sv
// Shared constants for the multi-core trace monitor: magic instruction encodings,
// monitor FSM state encoding and a helper for the core-index width.
package riscv_mpsoc_trace_pkg;

   // addi x0,x0,1 marks program exit; addi x0,x0,4 emits r3[7:0] as a character
   localparam logic [31:0] INSN_EXIT = 32'h00100013;
   localparam logic [31:0] INSN_PUTC = 32'h00400013;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DONE    = 2'd1,
      ST_TIMEOUT = 2'd2
   } trace_state_t;

   function automatic int core_idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/riscv_trace_putc_fifo.sv
// Small first-word-fall-through FIFO carrying {core, char} beats to the putc stream.
// Head entry is read combinationally so a pushed beat is visible the following cycle.
module riscv_trace_putc_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_reg;
   logic [AW:0]      rd_ptr_reg;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr_reg == rd_ptr_reg);
   assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg[AW-1:0]] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   // Storage is not reset, so hide stale contents while empty
   assign head_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/riscv_mpsoc_trace_monitor.sv
// Watches retire traces of NUM_CORES cores: shadows the terminal register, decodes exit/putc,
// merges putc characters round-robin into one stream. Define RISCV_TRACE_MON_TIMEOUT_EN for the watchdog.
module riscv_mpsoc_trace_monitor
   import riscv_mpsoc_trace_pkg::*;
#(
   parameter int NUM_CORES      = 16,
   parameter int XLEN           = 32,
   parameter int TERM_REG       = 3,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYCLES = 1000000
)(
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [NUM_CORES-1:0]                 trace_valid,
   input  logic [NUM_CORES-1:0]                 trace_wben,
   input  logic [5*NUM_CORES-1:0]               trace_wbreg,
   input  logic [XLEN*NUM_CORES-1:0]            trace_wbdata,
   input  logic [32*NUM_CORES-1:0]              trace_insn,
   output logic                                 putc_valid,
   input  logic                                 putc_ready,
   output logic [7:0]                           putc_data,
   output logic [core_idx_bits(NUM_CORES)-1:0]  putc_core,
   output logic [NUM_CORES-1:0]                 termination,
   output logic                                 all_terminated,
   output logic                                 exit_fail,
   output logic                                 timeout,
   output logic                                 overflow,
   output logic [31:0]                          cycle_count
);

   localparam int          CORE_W   = core_idx_bits(NUM_CORES);
   localparam logic [4:0]  TERM_IDX = 5'(TERM_REG);

   logic [NUM_CORES-1:0]   hold_valid;
   logic [8*NUM_CORES-1:0] hold_data;
   logic [NUM_CORES-1:0]   grant;
   logic [NUM_CORES-1:0]   fail_hit;
   logic [NUM_CORES-1:0]   drop_hit;

   logic                   fifo_push;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [7:0]             push_char;
   logic [CORE_W-1:0]      push_core;
   logic [CORE_W+7:0]      head_entry;
   logic [CORE_W-1:0]      ptr_reg;
   logic [CORE_W-1:0]      ptr_next;

   trace_state_t           state_reg;
   trace_state_t           state_next;
   logic [31:0]            cycle_count_reg;
   logic                   exit_fail_reg;
   logic                   overflow_reg;

   // Per-core decode, register shadow, sticky termination and 1-entry putc hold
   for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [XLEN-1:0] r3_reg;
      logic            term_reg;
      logic            hold_valid_reg;
      logic [7:0]      hold_data_reg;
      logic [31:0]     insn;
      logic            active;
      logic            wb_hit;
      logic            exit_hit;
      logic            putc_hit;

      assign insn     = trace_insn[gi*32 +: 32];
      assign active   = trace_valid[gi] & ~term_reg;
      assign wb_hit   = active & trace_wben[gi] & (trace_wbreg[gi*5 +: 5] == TERM_IDX);
      assign exit_hit = active & (insn == INSN_EXIT);
      assign putc_hit = active & (insn == INSN_PUTC);

      // A full hold being drained this cycle frees its slot for the new character
      assign drop_hit[gi] = putc_hit & hold_valid_reg & ~grant[gi];
      assign fail_hit[gi] = exit_hit & (r3_reg != '0);

      always_ff @(posedge clk) begin
         if (rst) begin
            r3_reg         <= '0;
            term_reg       <= 1'b0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
         end else begin
            if (wb_hit) begin
               r3_reg <= trace_wbdata[gi*XLEN +: XLEN];
            end
            if (exit_hit) begin
               term_reg <= 1'b1;
            end
            if (putc_hit && !drop_hit[gi]) begin
               hold_valid_reg <= 1'b1;
               hold_data_reg  <= r3_reg[7:0];
            end else if (grant[gi]) begin
               hold_valid_reg <= 1'b0;
            end
         end
      end

      assign hold_valid[gi]         = hold_valid_reg;
      assign hold_data[gi*8 +: 8]   = hold_data_reg;
      assign termination[gi]        = term_reg;
   end

   // Round-robin: first pass scans from the pointer upward, second pass wraps below it
   always_comb begin
      grant     = '0;
      fifo_push = 1'b0;
      push_char = '0;
      push_core = '0;
      ptr_next  = ptr_reg;
      if (!fifo_full) begin
         for (int p = 0; p < 2; p++) begin
            for (int j = 0; j < NUM_CORES; j++) begin
               if (!fifo_push && hold_valid[j] &&
                   ((p == 0) ? (j >= int'(ptr_reg)) : (j < int'(ptr_reg)))) begin
                  fifo_push = 1'b1;
                  grant[j]  = 1'b1;
                  push_char = hold_data[j*8 +: 8];
                  push_core = CORE_W'(j);
                  ptr_next  = (j == NUM_CORES - 1) ? '0 : CORE_W'(j + 1);
               end
            end
         end
      end
   end

   riscv_trace_putc_fifo #(
      .WIDTH (CORE_W + 8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({push_core, push_char}),
      .pop       (putc_ready),
      .head_data (head_entry),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign putc_valid = ~fifo_empty;
   assign putc_data  = head_entry[7:0];
   assign putc_core  = head_entry[CORE_W+7:8];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_RUN: begin
            if ((&termination) && (hold_valid == '0) && fifo_empty) begin
               state_next = ST_DONE;
            end
`ifdef RISCV_TRACE_MON_TIMEOUT_EN
            else if (cycle_count_reg == 32'(TIMEOUT_CYCLES - 1)) begin
               state_next = ST_TIMEOUT;
            end
`endif
         end
         default: state_next = state_reg;
      endcase
   end

   // The count freezes on the cycle that leaves RUN, so it reports the last RUN index
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg         <= '0;
         cycle_count_reg <= '0;
         exit_fail_reg   <= 1'b0;
         overflow_reg    <= 1'b0;
      end else begin
         ptr_reg <= ptr_next;
         if (state_reg == ST_RUN && state_next == ST_RUN && cycle_count_reg != 32'hFFFF_FFFF) begin
            cycle_count_reg <= cycle_count_reg + 32'd1;
         end
         if (|fail_hit) begin
            exit_fail_reg <= 1'b1;
         end
         if (|drop_hit) begin
            overflow_reg <= 1'b1;
         end
      end
   end

   assign all_terminated = (state_reg == ST_DONE);
   assign exit_fail      = exit_fail_reg;
   assign overflow       = overflow_reg;
   assign cycle_count    = cycle_count_reg;

`ifdef RISCV_TRACE_MON_TIMEOUT_EN
   assign timeout = (state_reg == ST_TIMEOUT);
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mpsoc_trace_monitor.sv
// Directed bench for riscv_mpsoc_trace_monitor (4 cores, 8-deep FIFO, watchdog limit 100).
module tb_riscv_mpsoc_trace_monitor;

   localparam int NC  = 4;
   localparam int XL  = 32;
   localparam int FD  = 8;
   localparam int TO  = 100;
   localparam int CW  = 2;
   localparam logic [31:0] EXIT = 32'h00100013;
   localparam logic [31:0] PUTC = 32'h00400013;
   localparam logic [31:0] NOP  = 32'h00000013;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [NC-1:0]        trace_valid = '0;
   logic [NC-1:0]        trace_wben = '0;
   logic [5*NC-1:0]      trace_wbreg = '0;
   logic [XL*NC-1:0]     trace_wbdata = '0;
   logic [32*NC-1:0]     trace_insn = '0;
   logic                 putc_valid;
   logic                 putc_ready = 1'b1;
   logic [7:0]           putc_data;
   logic [CW-1:0]        putc_core;
   logic [NC-1:0]        termination;
   logic                 all_terminated;
   logic                 exit_fail;
   logic                 timeout;
   logic                 overflow;
   logic [31:0]          cycle_count;

   int n_assert = 0;
   int n_fail   = 0;

   riscv_mpsoc_trace_monitor #(
      .NUM_CORES      (NC),
      .XLEN           (XL),
      .TERM_REG       (3),
      .FIFO_DEPTH     (FD),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .trace_valid    (trace_valid),
      .trace_wben     (trace_wben),
      .trace_wbreg    (trace_wbreg),
      .trace_wbdata   (trace_wbdata),
      .trace_insn     (trace_insn),
      .putc_valid     (putc_valid),
      .putc_ready     (putc_ready),
      .putc_data      (putc_data),
      .putc_core      (putc_core),
      .termination    (termination),
      .all_terminated (all_terminated),
      .exit_fail      (exit_fail),
      .timeout        (timeout),
      .overflow       (overflow),
      .cycle_count    (cycle_count)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of test, expected finish before 500000");
      $fatal(1, "bench watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      trace_valid  = '0;
      trace_wben   = '0;
      trace_wbreg  = '0;
      trace_wbdata = '0;
      trace_insn   = '0;
   endtask

   // Inputs set before the call are sampled at this edge, then removed
   task automatic cycle();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   task automatic drive_wb(input int c, input logic [31:0] d);
      trace_valid[c]         = 1'b1;
      trace_wben[c]          = 1'b1;
      trace_wbreg[c*5 +: 5]  = 5'd3;
      trace_wbdata[c*32 +: 32] = d;
      trace_insn[c*32 +: 32] = NOP;
   endtask

   task automatic drive_insn(input int c, input logic [31:0] insn);
      trace_valid[c]         = 1'b1;
      trace_insn[c*32 +: 32] = insn;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      putc_ready = 1'b1;
      clear_inputs();
      cycle();
      cycle();
      rst = 1'b0;
      check("rst_putc_valid", 64'(putc_valid), 64'(0));
      check("rst_putc_data", 64'(putc_data), 64'(0));
      check("rst_termination", 64'(termination), 64'(0));
      check("rst_all_term", 64'(all_terminated), 64'(0));
      check("rst_exit_fail", 64'(exit_fail), 64'(0));
      check("rst_overflow", 64'(overflow), 64'(0));
      check("rst_timeout", 64'(timeout), 64'(0));
      check("rst_cycle_count", 64'(cycle_count), 64'(0));
   endtask

   initial begin
      // ---- single putc from core 2 ----
      do_reset();
      drive_wb(2, 32'h41);
      cycle();
      check("cnt_after_1", 64'(cycle_count), 64'(1));
      drive_insn(2, PUTC);
      cycle();
      check("a_valid_early", 64'(putc_valid), 64'(0));
      cycle();
      check("a_valid", 64'(putc_valid), 64'(1));
      check("a_data", 64'(putc_data), 64'(8'h41));
      check("a_core", 64'(putc_core), 64'(2));
      putc_ready = 1'b0;
      cycle();
      check("a_hold_valid", 64'(putc_valid), 64'(1));
      check("a_hold_data", 64'(putc_data), 64'(8'h41));
      putc_ready = 1'b1;
      cycle();
      check("a_popped", 64'(putc_valid), 64'(0));

      // ---- pending character discarded by reset ----
      putc_ready = 1'b0;
      drive_wb(1, 32'h55);
      cycle();
      drive_insn(1, PUTC);
      cycle();
      cycle();
      check("r_pending", 64'(putc_valid), 64'(1));
      do_reset();
      cycle();
      check("r_discarded", 64'(putc_valid), 64'(0));

      // ---- three cores putc in the same cycle ----
      do_reset();
      drive_wb(0, 32'h61);
      drive_wb(1, 32'h62);
      drive_wb(2, 32'h63);
      cycle();
      drive_insn(0, PUTC);
      drive_insn(1, PUTC);
      drive_insn(2, PUTC);
      cycle();
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("b_valid", 64'(putc_valid), 64'(1));
         check("b_core", 64'(putc_core), 64'(k));
         check("b_data", 64'(putc_data), 64'(8'h61 + k));
      end
      cycle();
      check("b_empty", 64'(putc_valid), 64'(0));
      check("b_overflow", 64'(overflow), 64'(0));

      // ---- back-to-back putcs with a stalled sink ----
      do_reset();
      putc_ready = 1'b0;
      drive_wb(0, 32'h30);
      cycle();
      for (int k = 0; k < FD + 2; k++) begin
         drive_wb(0, 32'h31 + k);
         drive_insn(0, PUTC);
         cycle();
         check("c_overflow", 64'(overflow), 64'((k == FD + 1) ? 1 : 0));
      end
      putc_ready = 1'b1;
      for (int m = 0; m < FD + 1; m++) begin
         check("c_valid", 64'(putc_valid), 64'(1));
         check("c_data", 64'(putc_data), 64'(8'h30 + m));
         check("c_core", 64'(putc_core), 64'(0));
         cycle();
      end
      cycle();
      check("c_drained", 64'(putc_valid), 64'(0));
      check("c_overflow_sticky", 64'(overflow), 64'(1));

      // ---- all cores exit cleanly ----
      do_reset();
      for (int c = 0; c < NC; c++) drive_insn(c, EXIT);
      cycle();
      check("d_termination", 64'(termination), 64'(4'hF));
      check("d_not_done_yet", 64'(all_terminated), 64'(0));
      cycle();
      check("d_all_term", 64'(all_terminated), 64'(1));
      check("d_exit_fail", 64'(exit_fail), 64'(0));
      check("d_count_frozen", 64'(cycle_count), 64'(1));
      drive_wb(1, 32'h7A);
      cycle();
      drive_insn(1, PUTC);
      cycle();
      cycle();
      check("d_ignored_putc", 64'(putc_valid), 64'(0));
      check("d_still_done", 64'(all_terminated), 64'(1));
      check("d_count_still", 64'(cycle_count), 64'(1));

      // ---- one core exits with nonzero code ----
      do_reset();
      drive_wb(1, 32'h5);
      cycle();
      for (int c = 0; c < NC; c++) drive_insn(c, EXIT);
      cycle();
      check("e_exit_fail", 64'(exit_fail), 64'(1));
      check("e_termination", 64'(termination), 64'(4'hF));
      cycle();
      check("e_all_term", 64'(all_terminated), 64'(1));

      // ---- watchdog ----
      do_reset();
`ifdef RISCV_TRACE_MON_TIMEOUT_EN
      repeat (TO - 1) cycle();
      check("t_before", 64'(timeout), 64'(0));
      check("t_count_99", 64'(cycle_count), 64'(TO - 1));
      cycle();
      check("t_timeout", 64'(timeout), 64'(1));
      check("t_count_frozen", 64'(cycle_count), 64'(TO - 1));
      cycle();
      check("t_count_still", 64'(cycle_count), 64'(TO - 1));
      check("t_not_done", 64'(all_terminated), 64'(0));
`else
      repeat (TO + 20) cycle();
      check("t_no_timeout", 64'(timeout), 64'(0));
      check("t_count_runs", 64'(cycle_count), 64'(TO + 20));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_mpsoc_trace_monitor.md
RISCV_MPSOC_TRACE_MONITOR -- requirements
Module: riscv_mpsoc_trace_monitor

Interface
REQ-001 SHALL have parameter NUM_CORES, default 16, number of monitored cores (1..64).
REQ-002 SHALL have parameter XLEN, default 32, writeback data width.
REQ-003 SHALL have parameter TERM_REG, default 3, register index shadowed for exit code and putc character.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, putc FIFO entries (power of 2, >=2).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1000000, watchdog limit.
REQ-006 SHALL have port clk  in  1  system clock; all logic is on its rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-008 SHALL have port trace_valid  in  NUM_CORES  per-core retire strobe.
REQ-009 SHALL have port trace_wben  in  NUM_CORES  per-core writeback enable.
REQ-010 SHALL have port trace_wbreg  in  5*NUM_CORES  per-core writeback register index.
REQ-011 SHALL have port trace_wbdata  in  XLEN*NUM_CORES  per-core writeback data.
REQ-012 SHALL have port trace_insn  in  32*NUM_CORES  per-core retired instruction.
REQ-013 SHALL have port putc_valid  out  1,  putc_ready  in  1,  putc_data  out  8,  putc_core  out  max(1,$clog2(NUM_CORES)): character stream.
REQ-014 SHALL have port termination  out  NUM_CORES  sticky per-core terminated flags.
REQ-015 SHALL have ports all_terminated, exit_fail, timeout, overflow  out  1 each; cycle_count  out  32.

Function
REQ-016 Shadow r3[i] SHALL load wbdata[i] one cycle after trace_valid&wben&(wbreg==TERM_REG); reset 0.
REQ-017 Retired insn 32'h00100013 (exit) SHALL set termination[i] next cycle and exit_fail if shadow r3[i] (pre-update value) is nonzero.
REQ-018 Retired insn 32'h00400013 (putc) SHALL load core i's 1-entry hold register with r3[i][7:0]; if hold is full, character is dropped and overflow set (sticky).
REQ-019 A round-robin arbiter SHALL move at most one full hold register per cycle into the FIFO when not full, starting search after last granted core.
REQ-020 FIFO head SHALL drive putc_valid/putc_data/putc_core; entry pops on putc_valid&putc_ready; data stable while valid&!ready.
REQ-021 Trace events from a core with termination set SHALL be ignored.
REQ-022 FSM states RUN, DONE, TIMEOUT; RUN->DONE when all termination bits set, all hold registers and FIFO empty; DONE and TIMEOUT are terminal until rst.
REQ-023 all_terminated SHALL be 1 exactly in DONE; cycle_count SHALL increment each RUN cycle, saturating at 32'hFFFFFFFF.
REQ-024 Simultaneous hold write and arbiter grant of the same core SHALL grant old char and keep new char (no overflow).

Reset
REQ-025 On rst all outputs SHALL be 0, FSM RUN, FIFO/holds empty, arbiter pointer 0; rst mid-stream discards pending characters.

Configuration
REQ-026 With RISCV_TRACE_MON_TIMEOUT_EN defined, RUN->TIMEOUT when cycle_count reaches TIMEOUT_CYCLES-1, timeout=1; without it, timeout tied 0 and TIMEOUT unreachable.

Structure
REQ-027 Package riscv_mpsoc_trace_pkg SHALL hold insn constants (EXIT, PUTC) and the FSM state enum.
REQ-028 FIFO SHALL be sub-module riscv_trace_putc_fifo (parametrised width/depth, full/empty, sync reset).

Verification
REQ-029 Core 2 writes x3=0x41, putc -> one beat data 0x41, core 2, 2 cycles after retire.
REQ-030 Cores 0,1,2 putc same cycle, ready=1 -> three beats cores 0,1,2 in order, overflow=0.
REQ-031 putc_ready=0, core 0 issues 2+FIFO_DEPTH putcs -> overflow=1, first FIFO_DEPTH+1 chars retained.
REQ-032 All cores exit with x3=0 -> all_terminated=1, exit_fail=0; one core x3=5 -> exit_fail=1.
REQ-033 Macro defined, TIMEOUT_CYCLES=100, no exits -> timeout=1 at cycle 100, cycle_count frozen at 99.
